// File: rtl/alu_bit_serial_seq.sv
// Bit-serial sequencer that drives an external 1-bit ALU slice LSB first; shift groups finish in one cycle.
// Optional overflow output rsp_ovf_o is enabled by defining ALU_SEQ_OVF_EN.
module alu_bit_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    input  logic             req_cin_i,
    input  logic [3:0]       req_sel_i,
    output logic             slice_a_o,
    output logic             slice_b_o,
    output logic             slice_cin_o,
    output logic [3:0]       slice_sel_o,
    input  logic             slice_f_i,
    input  logic             slice_cout_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_f_o,
    output logic             rsp_cout_o
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic             rsp_ovf_o
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [3:0]       sel_q, sel_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cin_q, cin_d;
    logic             carry_q, carry_d;
`ifdef ALU_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic run;
    logic accept;

    assign run         = (state_q == S_RUN);
    assign req_ready_o = (state_q == S_IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;

    // Carry for bit 0 comes from the request; later bits chain the previous slice carry.
    assign slice_a_o   = run && a_q[cnt_q];
    assign slice_b_o   = run && b_q[cnt_q];
    assign slice_cin_o = run && ((cnt_q == '0) ? cin_q : carry_q);
    assign slice_sel_o = run ? sel_q : 4'b0000;

    assign rsp_valid_o = (state_q == S_DONE);
    assign rsp_f_o     = f_q;
    assign rsp_cout_o  = carry_q;
`ifdef ALU_SEQ_OVF_EN
    assign rsp_ovf_o   = ovf_q;
`endif

    // NOTE: every next-state signal takes its held value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        cin_d   = cin_q;
        carry_d = carry_q;
`ifdef ALU_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    cin_d   = req_cin_i;
                    sel_d   = req_sel_i;
                    cnt_d   = '0;
                    carry_d = 1'b0;
`ifdef ALU_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    if (!req_sel_i[3]) begin
                        f_d     = '0;
                        state_d = S_RUN;
                    end else begin
                        f_d     = req_sel_i[2] ? {req_a_i[WIDTH-2:0], 1'b0}
                                               : {1'b0, req_a_i[WIDTH-1:1]};
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                f_d[cnt_q] = slice_f_i;
                carry_d    = slice_cout_i;
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
`ifdef ALU_SEQ_OVF_EN
                    ovf_d   = (sel_q[3:2] == 2'b00) && (slice_cin_o ^ slice_cout_i);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    // NOTE: operand registers are reset too, keeping the slice pins and response outputs free of X.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
`ifdef ALU_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule
